i2s_in_stream_arbiter: RTL and testbench

- Frame-granular round-robin arbiter that merges the CN per-channel 8-bit AXI-stream outputs of the I2S capture block into one stream for the packetizer and uplink.
- Sits in the mclk domain, after the per-channel bclk→mclk CDC FIFOs.
- Each winning channel holds the output until its tlast beat. Output beats are tagged with the source channel index.
- A per-channel mask takes channels out of arbitration without breaking a frame that is already in flight.

---
 rtl/i2s_in_stream_arbiter_pkg.sv | 20 ++
 rtl/i2s_in_stream_arbiter_rr_priority_pick.sv | 33 +++
 rtl/i2s_in_stream_arbiter.sv | 145 ++++++++++++++
 tb/tb_i2s_in_stream_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_in_stream_arbiter_pkg.sv
// Shared types and constants for the I2S capture stream arbiter and its pick helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_in_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam logic [7:0] ABORT_FILL_BYTE     = 8'h00;
    localparam int         ARB_TIMEOUT_DEFAULT = 1024;

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } out_beat_t;

endpackage

// File: rtl/i2s_in_stream_arbiter_rr_priority_pick.sv
// Rotate-and-find-first: first set bit of req strictly after ptr, wrapping CN-1 -> 0.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rr_priority_pick #(
    parameter int CN  = 16,
    parameter int IDW = $clog2(CN)
) (
    input  logic [CN-1:0]  req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    int             cand;
    logic [IDW-1:0] cand_idx;

    // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = CN; i >= 1; i--) begin
            cand     = (int'(ptr) + i) % CN;
            cand_idx = IDW'(cand);
            if (req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/i2s_in_stream_arbiter.sv
// Frame-granular round-robin merge of CN byte streams; beats tagged with source index. Optional ARB_TIMEOUT_EN aborts starved frames.
// Latency: 1 cycle input handshake to m_axis_tvalid, plus one IDLE bubble per frame for arbitration.
// Backpressure: single output register; granted channel is ready only while that register is free.
module i2s_in_stream_arbiter
    import i2s_in_stream_arbiter_pkg::*;
#(
    parameter int CN      = 16,
    parameter int IDW     = $clog2(CN),
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic [CN-1:0]   s_axis_tvalid,
    output logic [CN-1:0]   s_axis_tready,
    input  logic [8*CN-1:0] s_axis_tdata,
    input  logic [CN-1:0]   s_axis_tlast,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [7:0]      m_axis_tdata,
    output logic            m_axis_tlast,
    output logic [IDW-1:0]  m_axis_tid,
    output logic            m_axis_tuser,
    input  logic [CN-1:0]   i_channel_mask,
    output logic            o_busy,
    output logic [31:0]     o_frame_count
);

    arb_state_t     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    out_beat_t      out_reg;
    logic           slot_free;
    logic           s_hs;
    logic [7:0]     s_dat_arr [CN];

    rr_priority_pick #(.CN(CN), .IDW(IDW)) u_pick (
        .req   (s_axis_tvalid & i_channel_mask),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < CN; i++) begin
            s_dat_arr[i] = s_axis_tdata[8*i +: 8];
        end
    end

    assign slot_free     = !m_axis_tvalid || m_axis_tready;
    assign s_hs          = (state == XFER) && slot_free && s_axis_tvalid[grant];
    assign m_axis_tdata  = out_reg.dat;
    assign m_axis_tlast  = out_reg.last;
    assign o_busy        = (state == XFER);

    always_comb begin
        s_axis_tready = '0;
        if (state == XFER) begin
            s_axis_tready[grant] = slot_free;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [31:0] starve_cnt;
    logic        tuser_reg;
    assign m_axis_tuser = tuser_reg;
`else
    assign m_axis_tuser = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state         <= IDLE;
            ptr           <= IDW'(CN - 1);
            grant         <= '0;
            out_reg       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tid    <= '0;
            o_frame_count <= '0;
`ifdef ARB_TIMEOUT_EN
            starve_cnt    <= '0;
            tuser_reg     <= 1'b0;
`endif
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                if (out_reg.last) begin
                    o_frame_count <= o_frame_count + 32'd1;
                end
            end
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        ptr   <= pick_idx;
                        state <= XFER;
`ifdef ARB_TIMEOUT_EN
                        starve_cnt <= '0;
`endif
                    end
                end
                XFER: begin
                    if (s_hs) begin
                        m_axis_tvalid <= 1'b1;
                        out_reg.dat   <= s_dat_arr[grant];
                        out_reg.last  <= s_axis_tlast[grant];
                        m_axis_tid    <= grant;
`ifdef ARB_TIMEOUT_EN
                        tuser_reg     <= 1'b0;
                        starve_cnt    <= '0;
`endif
                        if (s_axis_tlast[grant]) begin
                            state <= IDLE;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (!s_axis_tvalid[grant]) begin
                        starve_cnt <= starve_cnt + 32'd1;
                        if (starve_cnt + 32'd1 == 32'(TIMEOUT)) begin
                            state <= ABORT;
                        end
                    end
`endif
                end
`ifdef ARB_TIMEOUT_EN
                ABORT: begin
                    // Close the stalled frame with a flagged filler beat so the packetizer can drop it.
                    if (slot_free) begin
                        m_axis_tvalid <= 1'b1;
                        out_reg.dat   <= ABORT_FILL_BYTE;
                        out_reg.last  <= 1'b1;
                        tuser_reg     <= 1'b1;
                        m_axis_tid    <= grant;
                        starve_cnt    <= '0;
                        state         <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_in_stream_arbiter.sv
// Directed bench for i2s_in_stream_arbiter with CN=4, TIMEOUT=8; queue-based sources and an output log.
module tb_i2s_in_stream_arbiter;

    localparam int CN = 4;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [CN-1:0] s_axis_tvalid = '0;
    logic [CN-1:0] s_axis_tready;
    logic [8*CN-1:0] s_axis_tdata = '0;
    logic [CN-1:0] s_axis_tlast = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tlast;
    logic [1:0]    m_axis_tid;
    logic          m_axis_tuser;
    logic [CN-1:0] i_channel_mask = 4'hF;
    logic          o_busy;
    logic [31:0]   o_frame_count;

    i2s_in_stream_arbiter #(.CN(CN), .IDW(2), .TIMEOUT(8)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tid     (m_axis_tid),
        .m_axis_tuser   (m_axis_tuser),
        .i_channel_mask (i_channel_mask),
        .o_busy         (o_busy),
        .o_frame_count  (o_frame_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        rdy_tog = 1'b0;
    logic [8:0]  src_q [CN][$];
    logic [11:0] out_q [$];
    int          out_cyc [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] bt(input logic u, input logic [1:0] id, input logic l, input logic [7:0] d);
        return {u, id, l, d};
    endfunction

    task automatic push_frame(input int ch, input logic [7:0] b0, input int n);
        for (int i = 0; i < n; i++) src_q[ch].push_back({(i == n - 1), 8'(b0 + 8'(i))});
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, out_q.size() >= n, 1);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        for (int c = 0; c < CN; c++) src_q[c].delete();
        i_channel_mask = 4'hF;
        rdy_tog = 1'b0;
        repeat (2) step();
        out_q.delete();
        out_cyc.delete();
        arst_n = 1'b1;
    endtask

    // Source/sink model: capture handshakes at negedge, apply them just after posedge.
    initial begin
        logic [CN-1:0] s_hs;
        logic          held;
        logic [11:0]   held_val;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            s_hs = s_axis_tvalid & s_axis_tready;
            if (held && arst_n)
                check_eq("hold_out", {m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tdata}, held_val);
            held = m_axis_tvalid && !m_axis_tready && arst_n;
            held_val = {m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tdata};
            if (|s_axis_tready) begin
                check_eq("rdy_onehot", $countones(s_axis_tready), 1);
                check_eq("rdy_slot_free", (!m_axis_tvalid || m_axis_tready), 1);
            end
            if (m_axis_tvalid && m_axis_tready && arst_n) begin
                out_q.push_back({m_axis_tuser, m_axis_tid, m_axis_tlast, m_axis_tdata});
                out_cyc.push_back(cyc);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (arst_n)
                for (int c = 0; c < CN; c++) if (s_hs[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            for (int c = 0; c < CN; c++) begin
                s_axis_tvalid[c] = src_q[c].size() > 0;
                {s_axis_tlast[c], s_axis_tdata[8*c +: 8]} = (src_q[c].size() > 0) ? src_q[c][0] : 9'h0;
            end
            m_axis_tready = rdy_tog ? ~m_axis_tready : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        check_eq("rst_m_tvalid", m_axis_tvalid, 0);
        check_eq("rst_m_tdata", m_axis_tdata, 0);
        check_eq("rst_m_tlast", m_axis_tlast, 0);
        check_eq("rst_m_tid", m_axis_tid, 0);
        check_eq("rst_m_tuser", m_axis_tuser, 0);
        check_eq("rst_s_tready", s_axis_tready, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_frame_count", o_frame_count, 0);
        do_reset();

        // Two simultaneous frames: ch0 first, one bubble, then ch2
        push_frame(0, 8'hA0, 3);
        push_frame(2, 8'hC0, 3);
        wait_out(6, 60, "t1_wait");
        if (out_q.size() >= 6) begin
            check_eq("t1_b0", out_q[0], bt(0, 0, 0, 8'hA0));
            check_eq("t1_b1", out_q[1], bt(0, 0, 0, 8'hA1));
            check_eq("t1_b2", out_q[2], bt(0, 0, 1, 8'hA2));
            check_eq("t1_b3", out_q[3], bt(0, 2, 0, 8'hC0));
            check_eq("t1_b4", out_q[4], bt(0, 2, 0, 8'hC1));
            check_eq("t1_b5", out_q[5], bt(0, 2, 1, 8'hC2));
            check_eq("t1_gap_a1", out_cyc[1] - out_cyc[0], 1);
            check_eq("t1_gap_a2", out_cyc[2] - out_cyc[0], 2);
            check_eq("t1_gap_c0", out_cyc[3] - out_cyc[0], 4);
            check_eq("t1_gap_c1", out_cyc[4] - out_cyc[3], 1);
        end
        repeat (2) step();
        check_eq("t1_frame_count", o_frame_count, 2);
        check_eq("t1_busy_idle", o_busy, 0);
        do_reset();

        // Continuous traffic: 20 two-byte frames, strict rotation 0,1,2,3
        for (int f = 0; f < 5; f++)
            for (int c = 0; c < CN; c++) push_frame(c, 8'(c * 64 + f * 8), 2);
        wait_out(40, 200, "t2_wait");
        if (out_q.size() >= 40)
            for (int k = 0; k < 20; k++) begin
                check_eq("t2_first", out_q[2*k],   bt(0, 2'(k % 4), 0, 8'((k % 4) * 64 + (k / 4) * 8)));
                check_eq("t2_last",  out_q[2*k+1], bt(0, 2'(k % 4), 1, 8'((k % 4) * 64 + (k / 4) * 8 + 1)));
            end
        repeat (2) step();
        check_eq("t2_frame_count", o_frame_count, 20);
        do_reset();

        // Toggling downstream ready during a 4-byte frame
        rdy_tog = 1'b1;
        push_frame(1, 8'hD0, 4);
        wait_out(4, 100, "t3_wait");
        repeat (4) step();
        check_eq("t3_count", out_q.size(), 4);
        if (out_q.size() >= 4)
            for (int i = 0; i < 4; i++) check_eq("t3_beat", out_q[i], bt(0, 1, (i == 3), 8'(8'hD0 + i)));
        check_eq("t3_frame_count", o_frame_count, 1);
        do_reset();

        // Mask: only ch1 may win; clearing its bit mid-frame lets the frame finish
        i_channel_mask = 4'b0010;
        push_frame(0, 8'h50, 2);
        push_frame(1, 8'h10, 2);
        push_frame(1, 8'h20, 3);
        push_frame(2, 8'h60, 2);
        push_frame(3, 8'h70, 2);
        wait_out(3, 60, "t4_wait_mid");
        i_channel_mask = 4'b0000;
        wait_out(5, 60, "t4_wait_end");
        repeat (20) step();
        check_eq("t4_count", out_q.size(), 5);
        if (out_q.size() >= 5) begin
            check_eq("t4_b0", out_q[0], bt(0, 1, 0, 8'h10));
            check_eq("t4_b1", out_q[1], bt(0, 1, 1, 8'h11));
            check_eq("t4_b2", out_q[2], bt(0, 1, 0, 8'h20));
            check_eq("t4_b3", out_q[3], bt(0, 1, 0, 8'h21));
            check_eq("t4_b4", out_q[4], bt(0, 1, 1, 8'h22));
        end
        check_eq("t4_busy", o_busy, 0);
        check_eq("t4_s_tready", s_axis_tready, 0);
        do_reset();

        // Reset asserted on the 2nd beat of a frame
        push_frame(0, 8'h60, 4);
        wait_out(2, 40, "t5_wait");
        arst_n = 1'b0;
        #1;
        check_eq("t5_m_tvalid", m_axis_tvalid, 0);
        check_eq("t5_m_tdata", m_axis_tdata, 0);
        check_eq("t5_m_tlast", m_axis_tlast, 0);
        check_eq("t5_m_tid", m_axis_tid, 0);
        check_eq("t5_s_tready", s_axis_tready, 0);
        check_eq("t5_busy", o_busy, 0);
        check_eq("t5_frame_count", o_frame_count, 0);
        do_reset();
        push_frame(0, 8'h71, 1);
        push_frame(1, 8'h81, 1);
        wait_out(2, 40, "t5_wait_after");
        if (out_q.size() >= 2) begin
            check_eq("t5_first_grant", out_q[0], bt(0, 0, 1, 8'h71));
            check_eq("t5_second_grant", out_q[1], bt(0, 1, 1, 8'h81));
        end
        do_reset();

        // Starved grant on ch3: one byte without tlast, then silence
        src_q[3].push_back({1'b0, 8'h33});
        wait_out(1, 20, "t6_wait_first");
        if (out_q.size() >= 1) check_eq("t6_b0", out_q[0], bt(0, 3, 0, 8'h33));
`ifdef ARB_TIMEOUT_EN
        wait_out(2, 40, "t6_wait_abort");
        if (out_q.size() >= 2) begin
            check_eq("t6_abort_beat", out_q[1], bt(1, 3, 1, 8'h00));
            check_eq("t6_abort_delay", out_cyc[1] - out_cyc[0], 9);
        end
        step();
        check_eq("t6_busy", o_busy, 0);
        check_eq("t6_frame_count", o_frame_count, 1);
`else
        repeat (30) step();
        check_eq("t6_count", out_q.size(), 1);
        check_eq("t6_busy_held", o_busy, 1);
        check_eq("t6_tuser", m_axis_tuser, 0);
        check_eq("t6_frame_count", o_frame_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
